// File: rtl/dataout_arbiter_pkg.sv
// dataout_arbiter_pkg: shared types, sizes and helpers for the output-bus arbiter
package dataout_arbiter_pkg;

    localparam int NSRC = 4;
    localparam int DW = 8;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Source index 0 is source 1 and lives in the top bit of every 4-bit vector
    function automatic logic [NSRC-1:0] src_oh(input logic [1:0] id);
        return 4'b1000 >> id;
    endfunction

endpackage

// File: rtl/dataout_arbiter_if.sv
// dataout_arbiter_if: request/control inputs and grant/status outputs of the arbiter
interface dataout_arbiter_if;
    import dataout_arbiter_pkg::*;

    logic [NSRC-1:0] req;
    logic            manual;
    logic [1:0]      manual_sel;
    logic            dout_ready;
    logic [NSRC-1:0] en;
    logic            dout_valid;
    logic [NSRC-1:0] ack;
    logic [1:0]      grant_id;
    logic            busy;
    logic            err_timeout;

    modport master (
        output req, manual, manual_sel, dout_ready,
        input  en, dout_valid, ack, grant_id, busy, err_timeout
    );

    modport slave (
        input  req, manual, manual_sel, dout_ready,
        output en, dout_valid, ack, grant_id, busy, err_timeout
    );

endinterface

// File: rtl/dataout_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search starting after the last winner
module rr_pick
    import dataout_arbiter_pkg::*;
(
    input  logic [NSRC-1:0] elig,
    input  logic [1:0]      ptr,
    output logic [NSRC-1:0] oh,
    output logic [1:0]      id
);

    logic [1:0] idx;
    logic       found;

    // Walk ptr+1, ptr+2, ... wrapping, and keep the first eligible source
    always_comb begin
        oh = '0;
        id = '0;
        found = 1'b0;
        idx = ptr;
        for (int k = 1; k <= NSRC; k++) begin
            idx = ptr + 2'(k);
            if (!found && elig[2'd3 - idx]) begin
                found = 1'b1;
                id = idx;
                oh = src_oh(idx);
            end
        end
    end

endmodule

// File: rtl/dataout_arbiter.sv
// dataout_arbiter: grants one of four sources the shared output byte bus
module dataout_arbiter
    import dataout_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input logic              clk,
    input logic              rst_n,
    dataout_arbiter_if.slave bus
);

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [NSRC-1:0] en_q, en_d;
    logic            valid_q, valid_d;
    logic [NSRC-1:0] ack_q, ack_d;
    logic [1:0]      gid_q, gid_d;
    logic            busy_q, busy_d;
    logic            err_q, err_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [1:0]      sync_q, sync_d;

    logic [NSRC-1:0] elig;
    logic [NSRC-1:0] pick_oh;
    logic [1:0]      pick_id;
    logic            held;
    logic            expired;

    // Manual mode narrows the field to the single selected source
    assign elig = bus.manual ? (bus.req & src_oh(bus.manual_sel)) : bus.req;
    assign held = |(bus.req & en_q);
    assign expired = !bus.dout_ready && held && cnt_q == LAST_CNT;

    rr_pick u_pick (
        .elig (elig),
        .ptr  (ptr_q),
        .oh   (pick_oh),
        .id   (pick_id)
    );

    // Next state and next registered outputs; arbitration waits for the release synchroniser
    always_comb begin
        state_d = state_q;
        en_d = en_q;
        valid_d = valid_q;
        ack_d = '0;
        err_d = 1'b0;
        gid_d = gid_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        sync_d = {sync_q[0], 1'b1};
        case (state_q)
            IDLE: begin
                if (sync_q[1] && |pick_oh) begin
                    state_d = GRANT;
                    en_d = pick_oh;
                    valid_d = 1'b1;
                    gid_d = pick_id;
                    cnt_d = '0;
                    ptr_d = bus.manual ? ptr_q : pick_id;
                end
            end
            GRANT: begin
                if (bus.dout_ready || !held || expired) begin
                    state_d = GAP;
                    en_d = '0;
                    valid_d = 1'b0;
                    ack_d = bus.dout_ready ? en_q : '0;
                    err_d = expired;
                    ptr_d = expired ? gid_q : ptr_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            GAP: state_d = IDLE;
            default: begin
                state_d = IDLE;
                en_d = '0;
                valid_d = 1'b0;
            end
        endcase
        busy_d = state_d != IDLE;
    end

    // State and output registers; reset clears the bus enables immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            en_q <= '0;
            valid_q <= 1'b0;
            ack_q <= '0;
            gid_q <= '0;
            busy_q <= 1'b0;
            err_q <= 1'b0;
            ptr_q <= 2'd3;
            cnt_q <= '0;
            sync_q <= '0;
        end else begin
            state_q <= state_d;
            en_q <= en_d;
            valid_q <= valid_d;
            ack_q <= ack_d;
            gid_q <= gid_d;
            busy_q <= busy_d;
            err_q <= err_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            sync_q <= sync_d;
        end
    end

    assign bus.en = en_q;
    assign bus.dout_valid = valid_q;
    assign bus.ack = ack_q;
    assign bus.grant_id = gid_q;
    assign bus.busy = busy_q;
    assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_dataout_arbiter.sv
// tb_dataout_arbiter: directed scenarios plus random traffic against a source-level model
module tb_dataout_arbiter;

    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_errors = 0;

    dataout_arbiter_if bus ();

    dataout_arbiter #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Model state in terms of source numbers 1..4 (0 = none)
    int m_owner = 0;
    bit m_gap = 0;
    int m_age = 0;
    int m_last = 4;
    int m_gid = 0;
    int m_ack = 0;
    bit m_err = 0;
    int m_w;
    int m_s;

    function automatic logic [3:0] oh_of(input int s);
        return (s == 0) ? 4'b0000 : 4'(4'b1000 >> (s - 1));
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: who owns the bus after each edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owner = 0;
            m_gap = 0;
            m_age = 0;
            m_last = 4;
            m_gid = 0;
            m_ack = 0;
            m_err = 0;
        end else begin
            m_ack = 0;
            m_err = 0;
            if (m_owner != 0) begin
                if (bus.dout_ready) begin
                    m_ack = m_owner;
                    m_owner = 0;
                    m_gap = 1;
                end else if (!bus.req[4 - m_owner]) begin
                    m_owner = 0;
                    m_gap = 1;
                end else if (m_age == TMO) begin
                    m_err = 1;
                    m_last = m_owner;
                    m_owner = 0;
                    m_gap = 1;
                end else begin
                    m_age++;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else begin
                m_w = 0;
                if (bus.manual) begin
                    if (bus.req[3 - bus.manual_sel]) m_w = bus.manual_sel + 1;
                end else begin
                    for (int k = 1; k <= 4; k++) begin
                        m_s = (m_last + k - 1) % 4 + 1;
                        if (m_w == 0 && bus.req[4 - m_s]) m_w = m_s;
                    end
                end
                if (m_w != 0) begin
                    m_owner = m_w;
                    m_age = 1;
                    m_gid = m_w - 1;
                    if (!bus.manual) m_last = m_w;
                end
            end
        end
    end

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        chk("m_en", bus.en, oh_of(m_owner));
        chk("m_valid", bus.dout_valid, m_owner != 0);
        chk("m_ack", bus.ack, oh_of(m_ack));
        chk("m_gid", bus.grant_id, 8'(m_gid));
        chk("m_busy", bus.busy, (m_owner != 0) || m_gap);
        chk("m_err", bus.err_timeout, m_err);
        chk("m_onehot", 8'($countones(bus.en) <= 1), 8'd1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.req = 4'b0000;
        bus.dout_ready = 1'b0;
        bus.manual = 1'b0;
        repeat (n) cyc();
    endtask

    initial begin
        logic [3:0] oh;
        bus.req = 4'b0000;
        bus.manual = 1'b0;
        bus.manual_sel = 2'd0;
        bus.dout_ready = 1'b0;
        cyc();
        chk("rst_en", bus.en, 8'h0);
        chk("rst_valid", bus.dout_valid, 8'h0);
        chk("rst_busy", bus.busy, 8'h0);
        chk("rst_gid", bus.grant_id, 8'h0);
        cyc();
        rst_n = 1'b1;
        idle(3);

        bus.req = 4'b1111;
        bus.dout_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            oh = 4'b1000 >> (n % 4);
            cyc();
            chk("rr_en", bus.en, 8'(oh));
            chk("rr_gid", bus.grant_id, 8'(n % 4));
            cyc();
            chk("rr_ack", bus.ack, 8'(oh));
            chk("rr_gap_en", bus.en, 8'h0);
            cyc();
            chk("rr_idle_busy", bus.busy, 8'h0);
            chk("rr_idle_ack", bus.ack, 8'h0);
        end
        idle(2);

        bus.manual = 1'b1;
        bus.manual_sel = 2'd2;
        bus.req = 4'b1111;
        bus.dout_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            cyc();
            chk("man_en", bus.en, 8'h2);
            cyc();
            chk("man_ack", bus.ack, 8'h2);
            cyc();
        end
        bus.manual = 1'b0;
        cyc();
        chk("man_ptr_kept", bus.en, 8'h4);
        cyc();
        idle(1);

        bus.req = 4'b0100;
        for (int n = 0; n < TMO; n++) begin
            cyc();
            chk("tmo_en", bus.en, 8'h4);
            chk("tmo_err_early", bus.err_timeout, 8'h0);
        end
        cyc();
        chk("tmo_err", bus.err_timeout, 8'h1);
        chk("tmo_gap_en", bus.en, 8'h0);
        chk("tmo_ack", bus.ack, 8'h0);
        chk("tmo_gap_busy", bus.busy, 8'h1);
        bus.req = 4'b0000;
        cyc();
        chk("tmo_err_once", bus.err_timeout, 8'h0);
        chk("tmo_idle_busy", bus.busy, 8'h0);

        bus.req = 4'b0010;
        cyc();
        chk("drop_rdy_en", bus.en, 8'h2);
        bus.req = 4'b0000;
        bus.dout_ready = 1'b1;
        cyc();
        chk("drop_rdy_ack", bus.ack, 8'h2);
        idle(1);
        bus.req = 4'b0001;
        cyc();
        chk("drop_en", bus.en, 8'h1);
        bus.req = 4'b0000;
        cyc();
        chk("drop_ack", bus.ack, 8'h0);
        chk("drop_gap_en", bus.en, 8'h0);
        chk("drop_gap_busy", bus.busy, 8'h1);
        cyc();
        chk("drop_idle_busy", bus.busy, 8'h0);

        bus.req = 4'b1000;
        cyc();
        chk("mtog_en", bus.en, 8'h8);
        bus.manual = 1'b1;
        bus.manual_sel = 2'd3;
        cyc();
        chk("mtog_hold_en", bus.en, 8'h8);
        chk("mtog_hold_gid", bus.grant_id, 8'h0);
        bus.dout_ready = 1'b1;
        cyc();
        chk("mtog_ack", bus.ack, 8'h8);
        idle(2);

        bus.req = 4'b1000;
        cyc();
        chk("rst_mid_en_before", bus.en, 8'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_en", bus.en, 8'h0);
        chk("rst_mid_valid", bus.dout_valid, 8'h0);
        chk("rst_mid_ack", bus.ack, 8'h0);
        cyc();
        cyc();
        rst_n = 1'b1;
        idle(3);
        bus.req = 4'b0001;
        cyc();
        chk("post_rst_en", bus.en, 8'h1);
        chk("post_rst_gid", bus.grant_id, 8'h3);
        bus.dout_ready = 1'b1;
        cyc();
        chk("post_rst_ack", bus.ack, 8'h1);
        idle(2);

        for (int n = 0; n < 4000; n++) begin
            cyc();
            if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
            if ($urandom_range(0, 7) == 0) bus.manual = ~bus.manual;
            if ($urandom_range(0, 7) == 0) bus.manual_sel = 2'($urandom);
            bus.dout_ready = ($urandom_range(0, 3) == 0);
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dataout_arbiter.md
DATAOUT_ARBITER -- requirements
Module: dataout_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum cycles a grant waits for dout_ready before being dropped (legal range 1..255).
REQ-002 Port clk, input, 1: SHALL be the single clock; all state changes on its rising edge.
REQ-003 Port rst_n, input, 1: SHALL be the reset, asynchronous and active-low.
REQ-004 Port req, input, 4: SHALL carry the requests from sources 1..4; bit 3 is source 1.
REQ-005 Port manual, input, 1: SHALL select manual mode when 1 and auto mode when 0.
REQ-006 Port manual_sel, input, 2: SHALL give the only eligible source in manual mode; 0 is source 1.
REQ-007 Port dout_ready, input, 1: SHALL be the consumer acceptance of the byte on the shared bus.
REQ-008 Port en, output, 4: SHALL be the one-hot mux enables (en1..en4 = en[3:0]).
REQ-009 Port dout_valid, output, 1: SHALL qualify the shared output byte.
REQ-010 Port ack, output, 4: SHALL give a one-cycle completion pulse to the granted source.
REQ-011 Port grant_id, output, 2: SHALL give the encoded current or last winner.
REQ-012 Port busy, output, 1: SHALL be high in any state other than IDLE.
REQ-013 Port err_timeout, output, 1: SHALL give a one-cycle pulse when a grant expires.

Function
REQ-014 The FSM SHALL have the states IDLE, GRANT and GAP; all outputs SHALL be registered.
REQ-015 In IDLE with at least one eligible request, the arbiter SHALL pick a winner and enter GRANT on the next edge; en and dout_valid SHALL rise in that same cycle (1-cycle latency from req).
REQ-016 Eligibility in auto mode SHALL be req[3:0]; in manual mode it SHALL be req masked to the manual_sel bit only.
REQ-017 Auto pick SHALL be round-robin, searching from the source after the last winner, wrapping 4 to 1; after reset the pointer SHALL favour source 1 first.
REQ-018 Manual mode SHALL NOT update the round-robin pointer.
REQ-019 In GRANT, en SHALL hold exactly one bit high and dout_valid SHALL be high.
REQ-020 When dout_valid and dout_ready are both high, ack for the winner SHALL pulse on the next cycle and the FSM SHALL enter GAP.
REQ-021 If the winner's req falls in GRANT without dout_ready, the grant SHALL abort to GAP with no ack.
REQ-022 If the winner's req falls and dout_ready is high in the same cycle, the transfer SHALL complete and ack SHALL pulse.
REQ-023 A GRANT lasting TIMEOUT cycles without dout_ready SHALL pulse err_timeout, enter GAP and advance the pointer past the winner.
REQ-024 GAP SHALL last exactly 1 cycle with en = 0 and dout_valid = 0 (bus turnaround), then enter IDLE.
REQ-025 Back-to-back transfers SHALL therefore cost a minimum of 3 cycles each (IDLE, GRANT, GAP).
REQ-026 A change on manual or manual_sel during GRANT SHALL NOT affect the active grant; it SHALL apply at the next IDLE arbitration.
REQ-027 en SHALL never have more than one bit set in any cycle.

Reset
REQ-028 On rst_n low the block SHALL enter IDLE with en = 0, dout_valid = 0, ack = 0, busy = 0, err_timeout = 0, grant_id = 0, the pointer at source 4 (so source 1 wins next) and the timeout counter at 0.
REQ-029 Reset during GRANT SHALL drop en within that cycle asynchronously, with no ack.
REQ-030 Deassertion of reset SHALL be synchronised so that the first arbitration occurs no earlier than the second clk edge after release.

Structure
REQ-031 A shared package SHALL hold the FSM state type, the constants NSRC = 4 and DW = 8, and the TIMEOUT default.
REQ-032 The round-robin picker SHALL be one sub-module, rr_pick (4-bit eligible vector and 2-bit pointer in, one-hot and encoded winner out, combinational).

Verification
REQ-033 Bench SHALL check: reset, then req = 1111 with dout_ready held high -> grant order 1,2,3,4,1, one ack per transfer, 3 cycles per transfer.
REQ-034 Bench SHALL check: manual = 1, manual_sel = 2, req = 1111 -> only source 3 granted, repeatedly; pointer unchanged after returning to auto.
REQ-035 Bench SHALL check: TIMEOUT = 4, req = 0100, dout_ready = 0 -> en = 0100 for 4 cycles, err_timeout pulse, GAP, no ack.
REQ-036 Bench SHALL check: winner req drops in the same cycle as dout_ready -> ack pulses; req drops alone -> no ack, GAP.
REQ-037 Bench SHALL check: rst_n low mid-GRANT -> en = 0000 immediately; after release, req = 0001 -> source 4 granted.
REQ-038 Bench SHALL check: manual toggled during GRANT -> current grant completes unchanged.
